// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier controller.
// Holds the A/Q/Q-1 accumulator, the iteration counter and the start/busy/done
// handshake. Each RUN cycle it drives the Booth recode to an external add/sub
// unit and folds the returned result back into the accumulator.
module booth_mul_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [1:0]           booth_op,
    output logic [WIDTH-1:0]     as_a,
    output logic [WIDTH-1:0]     as_b,
    input  logic [WIDTH-1:0]     as_c
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    state_e            state_q;
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  mplr_q;
    logic [WIDTH-1:0]  mcand_q;
    logic              qm1_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              ov;
    logic              shift_in;

    assign as_a    = acc_q;
    assign as_b    = mcand_q;
    assign product = {acc_q, mplr_q};

    // Booth recode of the current multiplier LSB pair, only while iterating.
    always_comb begin
        booth_op = 2'b00;
        if (state_q == StRun) begin
            booth_op = {mplr_q[0], qm1_q};
        end
    end

    // Detect signed overflow of the add/sub so the shifted-in sign stays exact
    // (needed when M is the most negative value).
    always_comb begin
        ov = 1'b0;
        case (booth_op)
            2'b01:   ov = (acc_q[WIDTH-1] == mcand_q[WIDTH-1]) &&
                          (as_c[WIDTH-1] != acc_q[WIDTH-1]);
            2'b10:   ov = (acc_q[WIDTH-1] != mcand_q[WIDTH-1]) &&
                          (as_c[WIDTH-1] != acc_q[WIDTH-1]);
            default: ov = 1'b0;
        endcase
        shift_in = as_c[WIDTH-1] ^ ov;
    end

    // Controller FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            mplr_q  <= '0;
            mcand_q <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand_q <= multiplicand;
                        mplr_q  <= multiplier;
                        acc_q   <= '0;
                        qm1_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    // Arithmetic right shift of {S, Q, Q-1}.
                    acc_q  <= {shift_in, as_c[WIDTH-1:1]};
                    mplr_q <= {as_c[0], mplr_q[WIDTH-1:1]};
                    qm1_q  <= mplr_q[0];
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq with a behavioural add/sub unit.
module tb_booth_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] multiplicand = '0;
    logic [15:0] multiplier = '0;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic [1:0]  booth_op;
    logic [15:0] as_a;
    logic [15:0] as_b;
    logic [15:0] as_c;

    int passed = 0;
    int total  = 0;

    logic [31:0] exp_q[$];
    logic [1:0]  trace[4];

    booth_mul_seq #(.WIDTH(16), .CNT_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .booth_op     (booth_op),
        .as_a         (as_a),
        .as_b         (as_b),
        .as_c         (as_c)
    );

    always #5 clk = ~clk;

    // External add/sub unit.
    always_comb begin
        case (booth_op)
            2'b01:   as_c = as_a + as_b;
            2'b10:   as_c = as_a - as_b;
            default: as_c = as_a;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!busy) check("idle_booth_op", 64'(booth_op), 64'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_done: got done=1 product=0x%0h, expected no done",
                             product);
                end else begin
                    check("product", 64'(product), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // Issue one operation, check latency, busy width and single-cycle done.
    task automatic run_op(input logic [15:0] m, input logic [15:0] q, input logic [31:0] exp);
        int n;
        int busy_cycles;
        int tr_n;
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        busy_cycles = 0;
        tr_n = 0;
        while (!done && n < 40) begin
            if (busy) begin
                busy_cycles++;
                if (tr_n < 4) begin
                    trace[tr_n] = booth_op;
                    tr_n++;
                end
            end
            @(negedge clk);
            n++;
        end
        if (!done) begin
            total++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", n);
        end else begin
            check("done_latency", 64'(n), 64'd17);
            check("busy_cycles", 64'(busy_cycles), 64'd16);
        end
        @(negedge clk);
        check("done_pulse_width", 64'(done), 64'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] dummy;
        logic [15:0] rm;
        logic [15:0] rq;
        logic signed [31:0] rp;
        int n;

        #2 rst_n = 1'b0;
        #3;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", 64'(product), 64'd0);
        check("rst_booth_op", 64'(booth_op), 64'd0);
        check("rst_as_b", 64'(as_b), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 7 x 3 with booth_op trace: recodes 10, 11, 01, 00.
        run_op(16'h0007, 16'h0003, 32'h0000_0015);
        check("trace0", 64'(trace[0]), 64'd2);
        check("trace1", 64'(trace[1]), 64'd3);
        check("trace2", 64'(trace[2]), 64'd1);
        check("trace3", 64'(trace[3]), 64'd0);

        run_op(16'hFFFB, 16'h0006, 32'hFFFF_FFE2);
        run_op(16'h7FFF, 16'h7FFF, 32'h3FFF_0001);
        run_op(16'h8000, 16'h8000, 32'h4000_0000);
        run_op(16'h8000, 16'h0001, 32'hFFFF_8000);
        run_op(16'h8000, 16'h7FFF, 32'hC000_8000);
        run_op(16'hFFFF, 16'hFFFF, 32'h0000_0001);
        run_op(16'h0000, 16'h1234, 32'h0000_0000);

        // Back-to-back: start held high through RUN (ignored) and into DONE.
        @(negedge clk);
        multiplicand = 16'h0005;
        multiplier   = 16'h0003;
        start        = 1'b1;
        exp_q.push_back(32'h0000_000F);
        exp_q.push_back(32'hFFFF_FFFE);
        @(negedge clk);
        multiplicand = 16'h0002;
        multiplier   = 16'hFFFF;
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_latency", 64'(n), 64'd17);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
        end while (!done && n < 40);
        check("b2b_done_spacing", 64'(n), 64'd17);
        @(negedge clk);

        // Asynchronous reset during iteration 8.
        @(negedge clk);
        multiplicand = 16'h1234;
        multiplier   = 16'h5678;
        start        = 1'b1;
        exp_q.push_back(32'h0626_0060);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        dummy = exp_q.pop_back();
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_product", 64'(product), 64'd0);
        check("abort_booth_op", 64'(booth_op), 64'd0);
        check("abort_as_a", 64'(as_a), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        run_op(16'h1234, 16'h5678, 32'h0626_0060);

        // Random signed pairs against a plain multiply.
        for (int i = 0; i < 100; i++) begin
            rm = 16'($urandom);
            rq = 16'($urandom);
            rp = $signed(rm) * $signed(rq);
            run_op(rm, rq, 32'(rp));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
